panda_dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single data-memory port between the core load/store unit (port 0) and an auxiliary master such as debug or DMA (port 1). It sits between the LSU's memory-side outputs and the synchronous data RAM. It grants one request per cycle using round-robin priority, supports a lock for atomic read-modify-write sequences, and returns read data and completion to the owning master one cycle after grant.

---
 rtl/panda_dmem_arbiter_if.sv | 49 ++++
 rtl/panda_dmem_arbiter.sv | 111 +++++++++++
 tb/tb_panda_dmem_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/panda_dmem_arbiter_if.sv
// Bus bundle between the two data-memory masters, the arbiter and the data RAM.
// The arbiter takes the slave view; the environment (masters plus RAM) takes the master view.
interface panda_dmem_arbiter_if #(
    parameter int ADDR_W = 32
);
    // Port 0: core load/store unit
    logic              m0_req_i;
    logic [ADDR_W-1:0] m0_addr_i;
    logic [3:0]        m0_we_i;
    logic [31:0]       m0_wdata_i;
    logic              m0_gnt_o;
    logic              m0_rvalid_o;
    logic [31:0]       m0_rdata_o;

    // Port 1: auxiliary master (debug / DMA)
    logic              m1_req_i;
    logic [ADDR_W-1:0] m1_addr_i;
    logic [3:0]        m1_we_i;
    logic [31:0]       m1_wdata_i;
    logic              m1_lock_i;
    logic              m1_gnt_o;
    logic              m1_rvalid_o;
    logic [31:0]       m1_rdata_o;

    // Shared synchronous data RAM port
    logic              data_req_o;
    logic [ADDR_W-1:0] data_addr_o;
    logic [3:0]        data_we_o;
    logic [31:0]       data_wdata_o;
    logic [31:0]       data_rdata_i;

    modport slave (
        input  m0_req_i, m0_addr_i, m0_we_i, m0_wdata_i,
        output m0_gnt_o, m0_rvalid_o, m0_rdata_o,
        input  m1_req_i, m1_addr_i, m1_we_i, m1_wdata_i, m1_lock_i,
        output m1_gnt_o, m1_rvalid_o, m1_rdata_o,
        output data_req_o, data_addr_o, data_we_o, data_wdata_o,
        input  data_rdata_i
    );

    modport master (
        output m0_req_i, m0_addr_i, m0_we_i, m0_wdata_i,
        input  m0_gnt_o, m0_rvalid_o, m0_rdata_o,
        output m1_req_i, m1_addr_i, m1_we_i, m1_wdata_i, m1_lock_i,
        input  m1_gnt_o, m1_rvalid_o, m1_rdata_o,
        input  data_req_o, data_addr_o, data_we_o, data_wdata_o,
        output data_rdata_i
    );
endinterface

// File: rtl/panda_dmem_arbiter.sv
// Round-robin arbiter sharing one data-RAM port between the core LSU (port 0) and an
// auxiliary master (port 1), with a port-1 lock for atomic sequences and 1-cycle responses.
module panda_dmem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    panda_dmem_arbiter_if.slave  bus
);

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    port_e             r_last_grant;
    logic              r_locked;
    logic              r_resp_valid;
    port_e             r_resp_owner;

    logic              w_lock_hold;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_any_gnt;
    logic [ADDR_W-1:0] w_addr;
    logic [3:0]        w_we;
    logic [31:0]       w_wdata;

    // The lock only holds while port 1 keeps asserting it, so a drop frees port 0 the same cycle.
    assign w_lock_hold = r_locked & bus.m1_lock_i;

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!rst_i) begin
            if (w_lock_hold) begin
                w_gnt1 = bus.m1_req_i;
            end else if (bus.m0_req_i && bus.m1_req_i) begin
                if (r_last_grant == PORT1) begin
                    w_gnt0 = 1'b1;
                end else begin
                    w_gnt1 = 1'b1;
                end
            end else begin
                w_gnt0 = bus.m0_req_i;
                w_gnt1 = bus.m1_req_i;
            end
        end
    end

    assign w_any_gnt = w_gnt0 | w_gnt1;

    always_comb begin
        w_addr  = '0;
        w_we    = 4'b0000;
        w_wdata = '0;
        if (w_gnt0) begin
            w_addr  = bus.m0_addr_i;
            w_we    = bus.m0_we_i;
            w_wdata = bus.m0_wdata_i;
        end else if (w_gnt1) begin
            w_addr  = bus.m1_addr_i;
            w_we    = bus.m1_we_i;
            w_wdata = bus.m1_wdata_i;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_last_grant <= PORT1;
            r_locked     <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_owner <= PORT0;
        end else begin
            if (w_gnt0) begin
                r_last_grant <= PORT0;
            end else if (w_gnt1) begin
                r_last_grant <= PORT1;
            end

            if (w_gnt1 && bus.m1_lock_i) begin
                r_locked <= 1'b1;
            end else if (!bus.m1_lock_i) begin
                r_locked <= 1'b0;
            end

            r_resp_valid <= w_any_gnt;
            if (w_any_gnt) begin
                r_resp_owner <= w_gnt1 ? PORT1 : PORT0;
            end
        end
    end

    assign bus.m0_gnt_o     = w_gnt0;
    assign bus.m1_gnt_o     = w_gnt1;
    assign bus.data_req_o   = w_any_gnt;
    assign bus.data_addr_o  = w_addr;
    assign bus.data_we_o    = w_we;
    assign bus.data_wdata_o = w_wdata;

    // A response in flight when reset arrives is dropped rather than delivered.
    assign bus.m0_rvalid_o = ~rst_i & r_resp_valid & (r_resp_owner == PORT0);
    assign bus.m1_rvalid_o = ~rst_i & r_resp_valid & (r_resp_owner == PORT1);
    assign bus.m0_rdata_o  = bus.data_rdata_i;
    assign bus.m1_rdata_o  = bus.data_rdata_i;

endmodule

// File: tb/tb_panda_dmem_arbiter.sv
// Self-checking bench for panda_dmem_arbiter: directed scenarios followed by random
// traffic, all compared against a rule-level reference model.
module tb_panda_dmem_arbiter;
    localparam int ADDR_W = 32;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    panda_dmem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    panda_dmem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: last granted port, lock ownership, responses owed next cycle
    int m_last   = 1;
    bit m_locked = 1'b0;
    int resp_q[$];

    // Stimulus for the next cycle
    logic              s_r0, s_r1, s_lk;
    logic [ADDR_W-1:0] s_a0, s_a1;
    logic [3:0]        s_w0, s_w1;
    logic [31:0]       s_d0, s_d1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_m0(input logic req, input logic [ADDR_W-1:0] a, input logic [3:0] we,
                          input logic [31:0] d);
        s_r0 = req; s_a0 = a; s_w0 = we; s_d0 = d;
    endtask

    task automatic set_m1(input logic req, input logic [ADDR_W-1:0] a, input logic [3:0] we,
                          input logic [31:0] d, input logic lk);
        s_r1 = req; s_a1 = a; s_w1 = we; s_d1 = d; s_lk = lk;
    endtask

    // One clock cycle: drive, predict, check mid-cycle, advance the model.
    task automatic step(input logic rst, input logic [31:0] rdata, output int g);
        int owner;
        rst_i            = rst;
        bus.m0_req_i     = s_r0; bus.m0_addr_i = s_a0; bus.m0_we_i = s_w0; bus.m0_wdata_i = s_d0;
        bus.m1_req_i     = s_r1; bus.m1_addr_i = s_a1; bus.m1_we_i = s_w1; bus.m1_wdata_i = s_d1;
        bus.m1_lock_i    = s_lk;
        bus.data_rdata_i = rdata;

        g = -1;
        if (!rst) begin
            if (m_locked && s_lk) g = s_r1 ? 1 : -1;
            else if (s_r0 && s_r1) g = 1 - m_last;
            else if (s_r0) g = 0;
            else if (s_r1) g = 1;
        end
        owner = (!rst && resp_q.size() > 0) ? resp_q[0] : -1;

        @(negedge clk_i);
        check("m0_gnt", bus.m0_gnt_o, g == 0);
        check("m1_gnt", bus.m1_gnt_o, g == 1);
        check("data_req", bus.data_req_o, g >= 0);
        check("data_addr", bus.data_addr_o, g == 0 ? s_a0 : g == 1 ? s_a1 : '0);
        check("data_we", bus.data_we_o, g == 0 ? s_w0 : g == 1 ? s_w1 : 4'b0000);
        check("data_wdata", bus.data_wdata_o, g == 0 ? s_d0 : g == 1 ? s_d1 : 32'h0);
        check("m0_rvalid", bus.m0_rvalid_o, owner == 0);
        check("m1_rvalid", bus.m1_rvalid_o, owner == 1);
        if (owner == 0) check("m0_rdata", bus.m0_rdata_o, rdata);
        if (owner == 1) check("m1_rdata", bus.m1_rdata_o, rdata);

        resp_q.delete();
        if (rst) begin
            m_last   = 1;
            m_locked = 1'b0;
        end else begin
            if (g >= 0) begin
                m_last = g;
                resp_q.push_back(g);
            end
            if (g == 1 && s_lk) m_locked = 1'b1;
            else if (!s_lk) m_locked = 1'b0;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        set_m0(1'b0, '0, 4'b0000, 32'h0);
        set_m1(1'b0, '0, 4'b0000, 32'h0, 1'b0);
    endtask

    initial begin
        int g;
        logic [31:0] rd;
        idle_inputs();
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Reset state, with requests present to confirm they are masked
        set_m0(1'b1, 32'h40, 4'b1111, 32'h1111_1111);
        step(1'b1, 32'h0, g);
        idle_inputs();
        step(1'b1, 32'h0, g);

        // Single port-0 read, data returned next cycle
        set_m0(1'b1, 32'h100, 4'b0000, 32'h0);
        step(1'b0, 32'h0, g);
        idle_inputs();
        step(1'b0, 32'hDEAD_BEEF, g);

        // Contention after reset: 0,1,0,1
        step(1'b1, 32'h0, g);
        set_m0(1'b1, 32'h10, 4'b0000, 32'h0);
        set_m1(1'b1, 32'h20, 4'b0000, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 32'hA000_0000 + i, g);
        idle_inputs();
        step(1'b0, 32'hA000_0004, g);

        // Port-1 partial write, completion pulse next cycle
        set_m1(1'b1, 32'h30, 4'b0011, 32'h0000_ABCD, 1'b0);
        step(1'b0, 32'h0, g);
        idle_inputs();
        step(1'b0, 32'h5555_5555, g);

        // Lock request from a non-owner is ignored
        set_m0(1'b1, 32'h44, 4'b0000, 32'h0);
        set_m1(1'b0, '0, 4'b0000, 32'h0, 1'b1);
        step(1'b0, 32'h0, g);
        set_m1(1'b0, '0, 4'b0000, 32'h0, 1'b0);
        step(1'b0, 32'h0, g);

        // Locked read then locked write while port 0 keeps requesting
        set_m1(1'b1, 32'h200, 4'b0000, 32'h0, 1'b1);
        step(1'b0, 32'h0, g);
        set_m1(1'b1, 32'h200, 4'b1111, 32'hCAFE_F00D, 1'b1);
        step(1'b0, 32'h1234_5678, g);
        set_m1(1'b0, '0, 4'b0000, 32'h0, 1'b1);
        step(1'b0, 32'h0, g);
        set_m1(1'b0, '0, 4'b0000, 32'h0, 1'b0);
        step(1'b0, 32'h0, g);
        idle_inputs();
        step(1'b0, 32'h7777_0000, g);

        // Reset mid-operation discards the outstanding response
        set_m1(1'b1, 32'h60, 4'b1111, 32'h0BAD_0BAD, 1'b1);
        step(1'b0, 32'h0, g);
        step(1'b1, 32'h9999_9999, g);
        set_m0(1'b1, 32'h70, 4'b0000, 32'h0);
        set_m1(1'b1, 32'h74, 4'b0000, 32'h0, 1'b0);
        step(1'b0, 32'h0, g);

        // Idle for 3 cycles must not disturb the round-robin pointer
        idle_inputs();
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, g);
        set_m0(1'b1, 32'h80, 4'b0000, 32'h0);
        set_m1(1'b1, 32'h84, 4'b0000, 32'h0, 1'b0);
        step(1'b0, 32'h0, g);
        idle_inputs();
        step(1'b0, 32'h0, g);

        // Random traffic; masters hold their request until granted
        for (int i = 0; i < 400; i++) begin
            logic rst_now;
            if (!s_r0) set_m0($urandom_range(0, 1) == 1, $urandom, 4'($urandom), $urandom);
            if (!s_r1) set_m1($urandom_range(0, 1) == 1, $urandom, 4'($urandom), $urandom,
                              $urandom_range(0, 2) != 0);
            else s_lk = $urandom_range(0, 3) != 0;
            rst_now = ($urandom_range(0, 49) == 0);
            rd = $urandom;
            step(rst_now, rd, g);
            if (g == 0) s_r0 = 1'b0;
            if (g == 1) s_r1 = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
